// File: rtl/fixed_sub_stream_16.sv
// rtl/fixed_sub_stream_16.sv - streaming Q8.8 saturating subtractor, 2-stage pipeline
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid      - A/B operand pair valid
//   in_ready      - operand pair accepted this cycle
//   A, B          - signed Q8.8 minuend / subtrahend
//   out_valid     - Diff_Out valid
//   out_ready     - downstream accepts Diff_Out
//   Diff_Out      - signed Q8.8 result A - B (clamped when SAT_EN=1)
//   Sat_Flag      - presented result overflowed the Q8.8 range
//   sat_count     - number of saturated results delivered (sticks at max)
//   cnt_clr       - synchronous clear of sat_count

module fixed_sub_stream_16 #(
    parameter int CNT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      A,
    input  logic [15:0]      B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      Diff_Out,
    output logic             Sat_Flag,
    output logic [CNT_W-1:0] sat_count,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1 state: full-precision 17-bit difference
    logic signed [16:0] s1_diff;
    logic               s1_valid;

    // Stage 2 state
    logic               s2_valid;

    // Flow control
    logic adv1;
    logic adv2;

    // Stage 2 combinational result
    logic        ovf_pos;
    logic        ovf_neg;
    logic [15:0] sat_value;

    // Stage 2 advances whenever it is empty (bubble collapse) or drained.
    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    assign out_valid = s2_valid;

    // Bits 16 and 15 of the 17-bit difference disagree exactly when the
    // value lies outside the 16-bit signed range.
    assign ovf_pos = ~s1_diff[16] &  s1_diff[15];
    assign ovf_neg =  s1_diff[16] & ~s1_diff[15];

    always_comb begin
        sat_value = s1_diff[15:0];
        if (SAT_EN) begin
            if (ovf_pos) begin
                sat_value = 16'h7FFF;
            end else if (ovf_neg) begin
                sat_value = 16'h8000;
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s2_valid <= 1'b0;
            Diff_Out <= '0;
            Sat_Flag <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    Diff_Out <= sat_value;
                    Sat_Flag <= ovf_pos | ovf_neg;
                end
            end
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_diff <= $signed({A[15], A}) - $signed({B[15], B});
                end
            end
        end
    end

    // Saturation event counter; clear has priority over an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (cnt_clr) begin
            sat_count <= '0;
        end else if (s2_valid && out_ready && Sat_Flag && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fixed_sub_stream_16.sv
// tb/tb_fixed_sub_stream_16.sv - directed self-checking bench for fixed_sub_stream_16

module tb_fixed_sub_stream_16;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      A;
    logic [15:0]      B;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      Diff_Out;
    logic             Sat_Flag;
    logic [CNT_W-1:0] sat_count;
    logic             cnt_clr;

    int n_tests = 0;
    int n_fail  = 0;

    fixed_sub_stream_16 #(.CNT_W(CNT_W), .SAT_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff_Out  (Diff_Out),
        .Sat_Flag  (Sat_Flag),
        .sat_count (sat_count),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated transaction on an empty pipeline: checks the 2-cycle latency
    // and the result, then lets the result drain.
    task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_d, input logic exp_s);
        A = a;
        B = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " diff"},  32'(Diff_Out),  32'(exp_d));
        check({tag, " sat"},   32'(Sat_Flag),  32'(exp_s));
        @(posedge clk); #1;
    endtask

    // Backpressure stream vectors with hand-computed results
    logic [15:0] va [8] = '{16'h1000, 16'h0000, 16'h7000, 16'h9000,
                            16'h1234, 16'hFF00, 16'h0080, 16'h7FFF};
    logic [15:0] vb [8] = '{16'h0800, 16'h0001, 16'h9000, 16'h7000,
                            16'h0234, 16'hFF80, 16'hFF80, 16'h7FFF};
    logic [15:0] vd [8] = '{16'h0800, 16'hFFFF, 16'h7FFF, 16'h8000,
                            16'h1000, 16'hFF80, 16'h0100, 16'h0000};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [15:0] rdy_pat;
        logic [15:0] held_d;
        logic        held_s;
        logic        held;
        int          in_idx;
        int          out_idx;
        int          occ;
        int          cyc;
        logic        acc;
        logic        dlv;

        rst       = 1'b1;
        in_valid  = 1'b1;
        A         = 16'h1234;
        B         = 16'h0001;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset held for 2 cycles with in_valid high
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst diff",      32'(Diff_Out),  32'd0);
        check("rst sat_flag",  32'(Sat_Flag),  32'd0);
        check("rst sat_count", 32'(sat_count), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst in_ready",  32'(in_ready),  32'd1);

        // Basic and boundary subtractions
        send_one("sub 3-1.5",   16'h0300, 16'h0180, 16'h0180, 1'b0);
        send_one("sub 1-2",     16'h0100, 16'h0200, 16'hFF00, 1'b0);
        send_one("sat pos",     16'h7F00, 16'h8100, 16'h7FFF, 1'b1);
        send_one("sat neg",     16'h8100, 16'h7F00, 16'h8000, 1'b1);
        send_one("min-min",     16'h8000, 16'h8000, 16'h0000, 1'b0);
        check("sat_count 2", 32'(sat_count), 32'd2);
        send_one("min-1",       16'h8000, 16'h0001, 16'h8000, 1'b1);
        send_one("max-min",     16'h7FFF, 16'h8000, 16'h7FFF, 1'b1);
        send_one("edge +32768", 16'h4000, 16'hC000, 16'h7FFF, 1'b1);
        send_one("edge -32768", 16'hC000, 16'h4000, 16'h8000, 1'b0);
        check("sat_count 5", 32'(sat_count), 32'd5);

        // Backpressure stream against a fixed out_ready pattern
        rdy_pat = 16'b1010_0110_0011_1001;
        in_idx  = 0;
        out_idx = 0;
        occ     = 0;
        cyc     = 0;
        held    = 1'b0;
        held_d  = '0;
        held_s  = 1'b0;
        while (out_idx < 8 && cyc < 200) begin
            out_ready = rdy_pat[cyc % 16];
            in_valid  = (in_idx < 8);
            if (in_idx < 8) begin
                A = va[in_idx];
                B = vb[in_idx];
            end
            @(negedge clk);
            check("bp in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
            if (held) begin
                check("bp stall valid", 32'(out_valid), 32'd1);
                check("bp stall diff",  32'(Diff_Out),  32'(held_d));
                check("bp stall sat",   32'(Sat_Flag),  32'(held_s));
            end
            acc  = in_valid && in_ready;
            dlv  = out_valid && out_ready;
            held = out_valid && !out_ready;
            held_d = Diff_Out;
            held_s = Sat_Flag;
            if (dlv) begin
                check("bp diff", 32'(Diff_Out), 32'(vd[out_idx]));
                check("bp sat",  32'(Sat_Flag), 32'(vs[out_idx]));
                out_idx++;
            end
            if (acc) in_idx++;
            occ = occ + int'(acc) - int'(dlv);
            @(posedge clk); #1;
            cyc++;
        end
        check("bp all delivered", 32'(out_idx), 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp no duplicate", 32'(out_valid), 32'd0);
        check("bp sat_count", 32'(sat_count), 32'd7);

        // Counter saturates at 15 and does not wrap
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("cnt clear", 32'(sat_count), 32'd0);
        A = 16'h7F00;
        B = 16'h8100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt stick 15", 32'(sat_count), 32'd15);

        // Clear coincident with a saturated output transfer
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr xfer valid", 32'(out_valid & Sat_Flag), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr wins", 32'(sat_count), 32'd0);

        // Mid-stream reset with both stages full
        out_ready = 1'b0;
        A = 16'h0300;
        B = 16'h0100;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid full valid",    32'(out_valid), 32'd1);
        check("mid full in_ready", 32'(in_ready),  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst valid", 32'(out_valid), 32'd0);
        check("mid rst diff",  32'(Diff_Out),  32'd0);
        send_one("post rst", 16'h0010, 16'h0008, 16'h0008, 1'b0);
        check("post rst drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
